// File: rtl/perf_pkg.sv
// Shared types for the performance event collector: dump FSM states and the
// outbound record payload, sized for the largest supported configuration.
package perf_pkg;

    localparam int unsigned PERF_ID_W_MAX  = 16;
    localparam int unsigned PERF_CNT_W_MAX = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } perf_state_e;

    typedef struct packed {
        logic [PERF_ID_W_MAX-1:0]  id;
        logic [PERF_CNT_W_MAX-1:0] value;
        logic                      last;
    } perf_rec_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned perf_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// One live event counter: adds a small increment each cycle, sticks at all-ones,
// and can be reloaded in the cycle a snapshot is taken.
module perf_sat_counter #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] q
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] r_q;
    logic [SUM_W-1:0] w_sum;

    // Extra carry bit flags overflow so the counter clamps instead of wrapping.
    assign w_sum = SUM_W'(r_q) + SUM_W'(inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_value;
        end else if (w_sum[CNT_W]) begin
            r_q <= '1;
        end else begin
            r_q <= w_sum[CNT_W-1:0];
        end
    end

    assign q = r_q;

endmodule

// File: rtl/perf_event_collector.sv
// Performance event collector: per-event saturating counters, snapshotted on
// request or on a periodic timer, then streamed out one record per cycle.
module perf_event_collector
    import perf_pkg::*;
#(
    parameter int unsigned N_EVENTS      = 16,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned INC_W         = 2,
    parameter int unsigned DUMP_PERIOD   = 4096,
    parameter int unsigned CLEAR_ON_DUMP = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_EVENTS*INC_W-1:0]       ev_inc,
    input  logic                            dump_req,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [perf_idx_w(N_EVENTS)-1:0] out_id,
    output logic [CNT_W-1:0]                out_value,
    output logic                            out_last,
    output logic                            busy
);

    localparam int unsigned ID_W     = perf_idx_w(N_EVENTS);
    localparam int unsigned TMR_W    = perf_idx_w(DUMP_PERIOD);
    localparam int unsigned TMR_LAST = (DUMP_PERIOD == 0) ? 0 : DUMP_PERIOD - 1;
    localparam int unsigned ID_LAST  = N_EVENTS - 1;

    perf_state_e      r_state;
    perf_state_e      w_state_nxt;
    logic [ID_W-1:0]  r_idx;
    logic [ID_W-1:0]  w_idx_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    perf_rec_t        r_rec;
    perf_rec_t        w_rec_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_snap [N_EVENTS];
    logic [CNT_W-1:0] w_cnt  [N_EVENTS];
    logic             w_auto;
    logic             w_trig;
    logic             w_snap_take;
    logic             w_load;
    logic             w_rec_unused;

    // Live counters keep running through SEND; only the snapshot cycle reloads them.
    assign w_load = w_snap_take && (CLEAR_ON_DUMP != 0);

    for (genvar g = 0; g < N_EVENTS; g++) begin : g_cnt
        logic [INC_W-1:0] w_inc;
        assign w_inc = ev_inc[g*INC_W +: INC_W];

        perf_sat_counter #(
            .CNT_W (CNT_W),
            .INC_W (INC_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc        (w_inc),
            .load       (w_load),
            .load_value (CNT_W'(w_inc)),
            .q          (w_cnt[g])
        );
    end

    assign w_auto = (DUMP_PERIOD != 0) && (r_tmr == TMR_W'(TMR_LAST));
    assign w_trig = dump_req || w_auto;

    always_ff @(posedge clk) begin
        if (rst || (DUMP_PERIOD == 0) || w_auto) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + TMR_W'(1);
        end
    end

    // Next-state and next-record logic; the outbound record is registered.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pend_nxt  = r_pend;
        w_rec_nxt   = r_rec;
        w_snap_take = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_trig || r_pend) begin
                    w_snap_take     = 1'b1;
                    w_pend_nxt      = 1'b0;
                    w_state_nxt     = ST_SEND;
                    w_idx_nxt       = '0;
                    w_rec_nxt.id    = '0;
                    w_rec_nxt.value = PERF_CNT_W_MAX'(w_cnt[0]);
                    w_rec_nxt.last  = (N_EVENTS == 1);
                end
            end
            ST_SEND: begin
                if (w_trig) begin
                    w_pend_nxt = 1'b1;
                end
                if (out_ready) begin
                    if (r_idx == ID_W'(ID_LAST)) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_rec_nxt   = '0;
                    end else begin
                        w_idx_nxt       = r_idx + ID_W'(1);
                        w_rec_nxt.id    = PERF_ID_W_MAX'(w_idx_nxt);
                        w_rec_nxt.value = PERF_CNT_W_MAX'(r_snap[w_idx_nxt]);
                        w_rec_nxt.last  = (w_idx_nxt == ID_W'(ID_LAST));
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_rec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_pend  <= w_pend_nxt;
            r_rec   <= w_rec_nxt;
        end
    end

    // Snapshot holds the pre-increment counter values for the whole dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_EVENTS; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_snap_take) begin
            for (int i = 0; i < N_EVENTS; i++) begin
                r_snap[i] <= w_cnt[i];
            end
        end
    end

    assign out_valid = (r_state == ST_SEND);
    assign busy      = (r_state == ST_SEND);
    assign out_id    = r_rec.id[ID_W-1:0];
    assign out_value = r_rec.value[CNT_W-1:0];
    assign out_last  = r_rec.last;

    // Record fields are sized for the widest build; the upper bits stay zero.
    assign w_rec_unused = ^r_rec;

endmodule

// File: tb/tb_perf_event_collector.sv
// Directed bench for perf_event_collector: manual dumps, backpressure, saturation,
// snapshot-cycle increments, pending triggers, and periodic dumps across reset.
module tb_perf_event_collector;

    logic       clk;
    logic       rst;
    logic [7:0] ev_inc;
    logic       dump_req;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_id;
    logic [3:0] out_value;
    logic       out_last;
    logic       busy;

    logic       rst_p;
    logic [7:0] ev_p;
    logic       dump_p;
    logic       valid_p;
    logic       ready_p;
    logic [1:0] id_p;
    logic [3:0] value_p;
    logic       last_p;
    logic       busy_p;

    int tests_run;
    int tests_failed;

    logic [3:0] got_val [4];
    int         got_cnt;
    int         got_last_id;

    perf_event_collector #(
        .N_EVENTS      (4),
        .CNT_W         (4),
        .INC_W         (2),
        .DUMP_PERIOD   (0),
        .CLEAR_ON_DUMP (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ev_inc    (ev_inc),
        .dump_req  (dump_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_value (out_value),
        .out_last  (out_last),
        .busy      (busy)
    );

    perf_event_collector #(
        .N_EVENTS      (4),
        .CNT_W         (4),
        .INC_W         (2),
        .DUMP_PERIOD   (8),
        .CLEAR_ON_DUMP (1)
    ) dut_p (
        .clk       (clk),
        .rst       (rst_p),
        .ev_inc    (ev_p),
        .dump_req  (dump_p),
        .out_valid (valid_p),
        .out_ready (ready_p),
        .out_id    (id_p),
        .out_value (value_p),
        .out_last  (last_p),
        .busy      (busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Collect records from the current sample until out_valid drops.
    task automatic drain();
        int n;
        n = 0;
        got_cnt = 0;
        got_last_id = -1;
        for (int i = 0; i < 4; i++) got_val[i] = 4'hf;
        while (out_valid && n < 40) begin
            got_val[out_id] = out_value;
            if (out_last) got_last_id = int'(out_id);
            got_cnt++;
            tick();
            n++;
        end
    endtask

    task automatic run_dump(input logic [7:0] ev_at_snap);
        dump_req = 1'b1;
        ev_inc   = ev_at_snap;
        tick();
        dump_req = 1'b0;
        ev_inc   = 8'h00;
        drain();
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_p = 1'b1;
        ev_inc = 8'hff; dump_req = 1'b1; out_ready = 1'b1;
        ev_p = 8'h00; dump_p = 1'b0; ready_p = 1'b1;
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last: got %b expected 0", out_last); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (out_id !== 2'd0) begin tests_failed++; $display("FAIL reset_id: got %0d expected 0", out_id); end
        tests_run++;
        if (out_value !== 4'd0) begin tests_failed++; $display("FAIL reset_value: got %0d expected 0", out_value); end
        tests_run++;
        if (valid_p !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_p: got %b expected 0", valid_p); end
        ev_inc = 8'h00; dump_req = 1'b0;
        rst = 1'b0; rst_p = 1'b0;
    endtask

    task automatic test_basic_dump();
        logic [3:0] exp_v [4];
        exp_v[0] = 4'd0; exp_v[1] = 4'd0; exp_v[2] = 4'd10; exp_v[3] = 4'd0;
        ev_inc = 8'h10;
        repeat (10) tick();
        ev_inc = 8'h00;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_id !== 2'(k) || out_value !== exp_v[k] || out_last !== (k == 3)) begin
                tests_failed++;
                $display("FAIL basic_rec%0d: got v=%b id=%0d val=%0d last=%b expected v=1 id=%0d val=%0d last=%b",
                         k, out_valid, out_id, out_value, out_last, k, exp_v[k], (k == 3));
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_end: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        ev_inc = 8'h05;
        repeat (3) tick();
        ev_inc = 8'h00;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        n = 0;
        tests_run++;
        if (out_id !== 2'd0 || out_value !== 4'd3) begin
            tests_failed++; $display("FAIL bp_rec0: got id=%0d val=%0d expected 0 3", out_id, out_value);
        end
        tick(); n++;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick(); n++;
            tests_run++;
            if (out_valid !== 1'b1 || out_id !== 2'd1 || out_value !== 4'd3) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d val=%0d expected 1 1 3", s, out_valid, out_id, out_value);
            end
        end
        out_ready = 1'b1;
        while (out_valid && n < 50) begin tick(); n++; end
        tests_run++;
        if (n != 9) begin tests_failed++; $display("FAIL bp_length: got %0d cycles expected 9", n); end
    endtask

    task automatic test_saturation();
        ev_inc = 8'h03;
        repeat (6) tick();
        ev_inc = 8'h00;
        run_dump(8'h00);
        tests_run++;
        if (got_cnt != 4) begin tests_failed++; $display("FAIL sat_count: got %0d records expected 4", got_cnt); end
        tests_run++;
        if (got_val[0] !== 4'd15) begin tests_failed++; $display("FAIL sat_value: got %0d expected 15", got_val[0]); end
        tests_run++;
        if (got_last_id != 3) begin tests_failed++; $display("FAIL sat_last: got id %0d expected 3", got_last_id); end
    endtask

    task automatic test_simultaneous();
        ev_inc = 8'h04;
        repeat (4) tick();
        run_dump(8'h08);
        tests_run++;
        if (got_val[1] !== 4'd4) begin tests_failed++; $display("FAIL simul_first: got %0d expected 4", got_val[1]); end
        run_dump(8'h00);
        tests_run++;
        if (got_val[1] !== 4'd2) begin tests_failed++; $display("FAIL simul_second: got %0d expected 2", got_val[1]); end
    endtask

    task automatic test_pending();
        logic seen;
        ev_inc = 8'h40;
        repeat (2) tick();
        ev_inc = 8'h00;
        dump_req = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            tests_failed++; $display("FAIL pend_rec0: got v=%b id=%0d expected 1 0", out_valid, out_id);
        end
        ev_inc = 8'h40;
        tick();
        tests_run++;
        if (out_id !== 2'd1) begin tests_failed++; $display("FAIL pend_rec1: got id=%0d expected 1", out_id); end
        tick();
        dump_req = 1'b0;
        tests_run++;
        if (out_id !== 2'd2) begin tests_failed++; $display("FAIL pend_rec2: got id=%0d expected 2", out_id); end
        tick();
        tests_run++;
        if (out_id !== 2'd3 || out_last !== 1'b1 || out_value !== 4'd2) begin
            tests_failed++;
            $display("FAIL pend_rec3: got id=%0d last=%b val=%0d expected 3 1 2", out_id, out_last, out_value);
        end
        ev_inc = 8'h00;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL pend_gap: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            tests_failed++; $display("FAIL pend_restart: got v=%b id=%0d expected 1 0", out_valid, out_id);
        end
        drain();
        tests_run++;
        if (got_cnt != 4 || got_val[3] !== 4'd3) begin
            tests_failed++; $display("FAIL pend_second: got %0d records val3=%0d expected 4 3", got_cnt, got_val[3]);
        end
        seen = 1'b0;
        repeat (6) begin tick(); if (out_valid) seen = 1'b1; end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL pend_extra: got extra dump=%b expected 0", seen); end
    endtask

    task automatic test_period_reset();
        int n;
        ev_p = 8'h55;
        n = 0;
        while (!busy_p && n < 40) begin tick(); n++; end
        tests_run++;
        if (busy_p !== 1'b1) begin tests_failed++; $display("FAIL period_start: got busy=%b expected 1", busy_p); end
        tick();
        rst_p = 1'b1;
        tick();
        tests_run++;
        if (valid_p !== 1'b0 || busy_p !== 1'b0 || id_p !== 2'd0 || value_p !== 4'd0 || last_p !== 1'b0) begin
            tests_failed++;
            $display("FAIL period_rst: got v=%b busy=%b id=%0d val=%0d last=%b expected all 0",
                     valid_p, busy_p, id_p, value_p, last_p);
        end
        rst_p = 1'b0;
        ev_p = 8'h00;
        n = 0;
        while (!busy_p && n < 40) begin tick(); n++; end
        tests_run++;
        if (n != 8) begin tests_failed++; $display("FAIL period_delay: got %0d cycles expected 8", n); end
        tests_run++;
        if (id_p !== 2'd0 || value_p !== 4'd0) begin
            tests_failed++; $display("FAIL period_rec0: got id=%0d val=%0d expected 0 0", id_p, value_p);
        end
        tick();
        tests_run++;
        if (id_p !== 2'd1 || value_p !== 4'd0) begin
            tests_failed++; $display("FAIL period_rec1: got id=%0d val=%0d expected 1 0", id_p, value_p);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; rst_p = 1'b1;
        ev_inc = 8'h00; dump_req = 1'b0; out_ready = 1'b1;
        ev_p = 8'h00; dump_p = 1'b0; ready_p = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_dump();
        test_backpressure();
        test_saturation();
        test_simultaneous();
        test_pending();
        test_period_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
